// File: rtl/intc_regfile_if.sv
// Bus and interrupt signal bundle between a core-side master and the intc_regfile slave.
interface intc_regfile_if #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_IRQ-1:0]    irq_in;
    logic                  wr_en;
    logic [31:0]           wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_error;
    logic                  rd_en;
    logic [31:0]           rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_error;
    logic                  irq_out;
    logic [3:0]            irq_id;
    logic [DATA_WIDTH-1:0] irq_vector;
    logic                  irq_ack;

    modport master (
        output irq_in, wr_en, wr_addr, wr_data, rd_en, rd_addr, irq_ack,
        input  wr_error, rd_data, rd_valid, rd_error, irq_out, irq_id, irq_vector
    );

    modport slave (
        input  irq_in, wr_en, wr_addr, wr_data, rd_en, rd_addr, irq_ack,
        output wr_error, rd_data, rd_valid, rd_error, irq_out, irq_id, irq_vector
    );
endinterface

// File: rtl/intc_regfile.sv
// Interrupt-controller register bank: ISR vectors, enable mask, edge-captured pending bits,
// and a fixed-priority (lowest index wins) grant/acknowledge FSM toward the core.
module intc_regfile #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0002_0000
) (
    input logic           clk,
    input logic           rst,
    intc_regfile_if.slave bus
);
    localparam int unsigned OffEnable  = NUM_IRQ;
    localparam int unsigned OffPending = NUM_IRQ + 1;
    localparam int unsigned OffActive  = NUM_IRQ + 2;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                state;
    logic [DATA_WIDTH-1:0] vec_q [NUM_IRQ];
    logic [NUM_IRQ-1:0]    enable_q, pending_q, irq_prev_q;
    logic                  irq_out_q, rd_valid_q, rd_error_q, wr_error_q;
    logic [3:0]            irq_id_q;
    logic [DATA_WIDTH-1:0] irq_vector_q, rd_data_q;

    // Address decode: word index relative to the window base.
    logic [31:0] wr_rel, rd_rel;
    logic        wr_ok, rd_ok;
    assign wr_rel = bus.wr_addr - BASE_ADDR;
    assign rd_rel = bus.rd_addr - BASE_ADDR;
    assign rd_ok  = (bus.rd_addr >= BASE_ADDR) && (rd_rel[1:0] == 2'b00)
                    && (rd_rel[31:2] <= 30'(OffActive));
    assign wr_ok  = (bus.wr_addr >= BASE_ADDR) && (wr_rel[1:0] == 2'b00)
                    && (wr_rel[31:2] < 30'(OffActive));

    logic [NUM_IRQ-1:0] wr_vec_sel, enable_d, pending_d, clr, edges, id_onehot, req;
    logic               grant_live;
    assign edges = bus.irq_in & ~irq_prev_q;
    assign req   = pending_q & enable_q;

    always_comb begin
        enable_d   = enable_q;
        clr        = '0;
        wr_vec_sel = '0;
        id_onehot  = '0;
        for (int k = 0; k < int'(NUM_IRQ); k++) begin
            id_onehot[k] = (irq_id_q == 4'(k));
        end
        if (bus.wr_en && wr_ok) begin
            for (int k = 0; k < int'(NUM_IRQ); k++) begin
                wr_vec_sel[k] = (wr_rel[31:2] == 30'(k));
            end
            if (wr_rel[31:2] == 30'(OffEnable)) enable_d = bus.wr_data[NUM_IRQ-1:0];
            if (wr_rel[31:2] == 30'(OffPending)) clr = bus.wr_data[NUM_IRQ-1:0];
        end
        if (state == StGrant && bus.irq_ack) clr = clr | id_onehot;
        // A fresh edge beats any clear of the same bit.
        pending_d  = (pending_q & ~clr) | edges;
        grant_live = |(enable_d & pending_d & id_onehot);
    end

    logic [3:0]            arb_id;
    logic [DATA_WIDTH-1:0] arb_vec;
    always_comb begin
        arb_id  = '0;
        arb_vec = '0;
        for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
            if (req[k]) begin
                arb_id  = 4'(k);
                arb_vec = vec_q[k];
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_val;
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < int'(NUM_IRQ); k++) begin
            if (rd_rel[31:2] == 30'(k)) rd_val = vec_q[k];
        end
        if (rd_rel[31:2] == 30'(OffEnable)) rd_val = DATA_WIDTH'(enable_q);
        if (rd_rel[31:2] == 30'(OffPending)) rd_val = DATA_WIDTH'(pending_q);
        if (rd_rel[31:2] == 30'(OffActive)) begin
            rd_val[31]  = irq_out_q;
            rd_val[3:0] = irq_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NUM_IRQ); k++) vec_q[k] <= '0;
            enable_q     <= '0;
            pending_q    <= '0;
            irq_prev_q   <= bus.irq_in;
            state        <= StIdle;
            irq_out_q    <= 1'b0;
            irq_id_q     <= '0;
            irq_vector_q <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_error_q   <= 1'b0;
            wr_error_q   <= 1'b0;
        end else begin
            for (int k = 0; k < int'(NUM_IRQ); k++) begin
                if (wr_vec_sel[k]) vec_q[k] <= bus.wr_data;
            end
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            irq_prev_q <= bus.irq_in;
            rd_valid_q <= bus.rd_en;
            rd_error_q <= bus.rd_en && !rd_ok;
            rd_data_q  <= (bus.rd_en && rd_ok) ? rd_val : '0;
            wr_error_q <= bus.wr_en && !wr_ok;
            case (state)
                StIdle: begin
                    if (|req) begin
                        state        <= StGrant;
                        irq_out_q    <= 1'b1;
                        irq_id_q     <= arb_id;
                        irq_vector_q <= arb_vec;
                    end
                end
                StGrant: begin
                    // Ack completes the grant; a bus write removing enable/pending withdraws it.
                    if (bus.irq_ack || !grant_live) begin
                        state     <= StIdle;
                        irq_out_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    irq_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_error   = rd_error_q;
    assign bus.wr_error   = wr_error_q;
    assign bus.irq_out    = irq_out_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.irq_vector = irq_vector_q;
endmodule

// File: tb/tb_intc_regfile.sv
// Directed bench for intc_regfile: register-map vector table plus interrupt sequences.
module tb_intc_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    intc_regfile_if #(.NUM_IRQ(4), .DATA_WIDTH(32)) bus ();

    intc_regfile #(.NUM_IRQ(4), .DATA_WIDTH(32), .BASE_ADDR(32'h0002_0000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    localparam logic [31:0] B = 32'h0002_0000;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t tbl [18];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        tick();
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        bus.irq_in  = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        bus.irq_ack = 1'b0;

        // {is_wr, addr, wdata, exp_data (reads), exp_err}
        tbl[0]  = '{1'b0, B + 32'h00, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, B + 32'h04, 32'h0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, B + 32'h08, 32'h0, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, B + 32'h0C, 32'h0, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, B + 32'h10, 32'h0, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, B + 32'h14, 32'h0, 32'h0, 1'b0};
        tbl[6]  = '{1'b0, B + 32'h18, 32'h0, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, B + 32'h1C, 32'h0, 32'h0, 1'b1};
        tbl[8]  = '{1'b0, B + 32'h02, 32'h0, 32'h0, 1'b1};
        tbl[9]  = '{1'b0, B - 32'h04, 32'h0, 32'h0, 1'b1};
        tbl[10] = '{1'b1, B + 32'h18, 32'h1, 32'h0, 1'b1};
        tbl[11] = '{1'b1, B + 32'h01, 32'h5, 32'h0, 1'b1};
        tbl[12] = '{1'b0, B + 32'h00, 32'h0, 32'h0, 1'b0};
        tbl[13] = '{1'b1, B + 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0};
        tbl[14] = '{1'b0, B + 32'h10, 32'h0, 32'h0000_000F, 1'b0};
        tbl[15] = '{1'b1, B + 32'h04, 32'h1111_0011, 32'h0, 1'b0};
        tbl[16] = '{1'b0, B + 32'h04, 32'h0, 32'h1111_0011, 1'b0};
        tbl[17] = '{1'b1, B + 32'h10, 32'h0, 32'h0, 1'b0};

        tick();
        tick();
        check("rst_irq_out", 32'(bus.irq_out), 32'h0);
        check("rst_irq_id", 32'(bus.irq_id), 32'h0);
        check("rst_irq_vector", bus.irq_vector, 32'h0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("rst_wr_error", 32'(bus.wr_error), 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].is_wr) begin
                do_write(tbl[i].addr, tbl[i].wdata);
                check($sformatf("tbl%0d_wr_error", i), 32'(bus.wr_error), 32'(tbl[i].exp_err));
            end else begin
                do_read(tbl[i].addr);
                check($sformatf("tbl%0d_rd_valid", i), 32'(bus.rd_valid), 32'h1);
                check($sformatf("tbl%0d_rd_error", i), 32'(bus.rd_error), 32'(tbl[i].exp_err));
                check($sformatf("tbl%0d_rd_data", i), bus.rd_data, tbl[i].exp_data);
            end
        end
        tick();
        check("pulse_rd_valid_low", 32'(bus.rd_valid), 32'h0);
        check("pulse_wr_error_low", 32'(bus.wr_error), 32'h0);

        // Single-channel grant, vector latch and ack.
        do_write(B + 32'h08, 32'hDEAD_0040);
        do_write(B + 32'h10, 32'h4);
        bus.irq_in = 4'b0100;
        tick();
        check("a_no_irq_yet", 32'(bus.irq_out), 32'h0);
        bus.irq_in = 4'b0000;
        do_read(B + 32'h14);
        check("a_pending", bus.rd_data, 32'h4);
        check("a_irq_out", 32'(bus.irq_out), 32'h1);
        check("a_irq_id", 32'(bus.irq_id), 32'h2);
        check("a_irq_vector", bus.irq_vector, 32'hDEAD_0040);
        do_read(B + 32'h18);
        check("a_active", bus.rd_data, 32'h8000_0002);
        do_write(B + 32'h08, 32'h1234_5678);
        check("a_vec_held", bus.irq_vector, 32'hDEAD_0040);
        check("a_still_granted", 32'(bus.irq_out), 32'h1);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("a_ack_drop", 32'(bus.irq_out), 32'h0);
        do_read(B + 32'h14);
        check("a_pending_clr", bus.rd_data, 32'h0);

        // Priority: simultaneous edges on 3 and 1.
        do_write(B + 32'h10, 32'hF);
        bus.irq_in = 4'b1010;
        tick();
        tick();
        check("b_grant1_out", 32'(bus.irq_out), 32'h1);
        check("b_grant1_id", 32'(bus.irq_id), 32'h1);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("b_gap", 32'(bus.irq_out), 32'h0);
        tick();
        check("b_grant3_out", 32'(bus.irq_out), 32'h1);
        check("b_grant3_id", 32'(bus.irq_id), 32'h3);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        bus.irq_in  = 4'b0000;
        tick();
        check("b_done", 32'(bus.irq_out), 32'h0);

        // Line held high through reset release must not fire.
        bus.irq_in = 4'b0001;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        do_write(B + 32'h10, 32'h1);
        tick();
        tick();
        check("c_no_irq", 32'(bus.irq_out), 32'h0);
        do_read(B + 32'h14);
        check("c_no_pending", bus.rd_data, 32'h0);
        bus.irq_in = 4'b0000;
        tick();
        bus.irq_in = 4'b0001;
        tick();
        tick();
        check("c_grant_out", 32'(bus.irq_out), 32'h1);
        check("c_grant_id", 32'(bus.irq_id), 32'h0);
        // Reset mid-grant drops the request and discards pending.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("c_rst_drop", 32'(bus.irq_out), 32'h0);
        bus.irq_in = 4'b0000;
        do_read(B + 32'h14);
        check("c_rst_pending", bus.rd_data, 32'h0);

        // W1C withdraw, then ack colliding with a new edge on the granted line.
        do_write(B + 32'h10, 32'hF);
        bus.irq_in = 4'b0010;
        tick();
        bus.irq_in = 4'b0000;
        tick();
        check("d_grant_id", 32'(bus.irq_id), 32'h1);
        check("d_grant_out", 32'(bus.irq_out), 32'h1);
        do_write(B + 32'h14, 32'h2);
        check("d_withdraw", 32'(bus.irq_out), 32'h0);
        do_read(B + 32'h14);
        check("d_w1c_pending", bus.rd_data, 32'h0);
        tick();
        check("d_stay_idle", 32'(bus.irq_out), 32'h0);
        bus.irq_in = 4'b0010;
        tick();
        bus.irq_in = 4'b0000;
        tick();
        check("d_regrant_out", 32'(bus.irq_out), 32'h1);
        bus.irq_in  = 4'b0010;
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        bus.irq_in  = 4'b0000;
        check("d_ack_gap", 32'(bus.irq_out), 32'h0);
        do_read(B + 32'h14);
        check("d_set_wins", bus.rd_data, 32'h2);
        check("d_regrant2_out", 32'(bus.irq_out), 32'h1);
        check("d_regrant2_id", 32'(bus.irq_id), 32'h1);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("d_final_drop", 32'(bus.irq_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
